div_sequencer: RTL and testbench



---
 rtl/div_pkg.sv | 21 ++
 rtl/div_operand_prep.sv | 46 ++++
 rtl/div_sequencer.sv | 138 +++++++++++++
 tb/tb_div_sequencer.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared constants and enumerations for the restoring divider sequencer.
package div_pkg;

  localparam int XLEN_DEFAULT = 32;

  // Request opcode as presented by the pcpi decode logic.
  typedef enum logic [1:0] {
    DIV  = 2'b00,
    DIVU = 2'b01,
    REM  = 2'b10,
    REMU = 2'b11
  } div_op_e;

  // Sequencer control states.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } div_state_e;

endpackage

// File: rtl/div_operand_prep.sv
// Combinational operand conditioning feeding the accept edge: magnitudes,
// pre-shifted divisor and the sign flags used for the final correction.
module div_operand_prep
  import div_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic [1:0]        op,
  input  logic [XLEN-1:0]   rs1,
  input  logic [XLEN-1:0]   rs2,
  output logic [XLEN-1:0]   dividend,
  output logic [2*XLEN-2:0] divisor,
  output logic              div_zero,
  output logic              is_rem,
  output logic              outsign_q,
  output logic              outsign_r
);

  div_op_e                op_e;
  logic                   is_signed;
  logic                   neg1;
  logic                   neg2;
  logic signed [XLEN-1:0] rs1_s;
  logic signed [XLEN-1:0] rs2_s;
  logic [XLEN-1:0]        abs2;

  assign op_e      = div_op_e'(op);
  assign is_signed = (op_e == DIV) || (op_e == REM);
  assign is_rem    = (op_e == REM) || (op_e == REMU);

  assign rs1_s     = $signed(rs1);
  assign rs2_s     = $signed(rs2);
  assign neg1      = is_signed && rs1[XLEN-1];
  assign neg2      = is_signed && rs2[XLEN-1];

  assign dividend  = neg1 ? $unsigned(-rs1_s) : rs1;
  assign abs2      = neg2 ? $unsigned(-rs2_s) : rs2;
  // Divisor starts aligned so its LSB sits at the dividend MSB.
  assign divisor   = {abs2, {(XLEN-1){1'b0}}};

  assign div_zero  = (rs2 == '0);
  // A zero divisor yields an all-ones quotient regardless of signs.
  assign outsign_q = is_signed && (rs1[XLEN-1] != rs2[XLEN-1]) && !div_zero;
  assign outsign_r = neg1;

endmodule

// File: rtl/div_sequencer.sv
// Restoring divider controller: accepts one request, runs XLEN shift/subtract
// iterations on a 2*XLEN-1 bit divisor register, then holds the signed
// quotient or remainder until the consumer takes it.
module div_sequencer
  import div_pkg::*;
#(
  parameter int XLEN      = XLEN_DEFAULT,
  parameter bit ZERO_FAST = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [1:0]      req_op,
  input  logic [XLEN-1:0] req_rs1,
  input  logic [XLEN-1:0] req_rs2,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_data,
  output logic            busy
);

  localparam int               DW       = 2*XLEN-1;
  localparam int               CNT_W    = $clog2(XLEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN-1);

  div_state_e        state;
  div_state_e        state_nxt;

  logic [XLEN-1:0]   dividend;
  logic [DW-1:0]     divisor;
  logic [XLEN-1:0]   quotient;
  logic [XLEN-1:0]   mask;
  logic [CNT_W-1:0]  cnt;
  logic              is_rem;
  logic              outsign_q;
  logic              outsign_r;

  logic [XLEN-1:0]   p_dividend;
  logic [DW-1:0]     p_divisor;
  logic              p_zero;
  logic              p_is_rem;
  logic              p_outsign_q;
  logic              p_outsign_r;

  logic              accept;
  logic              take;
  logic [XLEN-1:0]   dividend_nxt;
  logic [XLEN-1:0]   quotient_nxt;

  // Two's-complement negate when the result sign must be flipped.
  function automatic logic [XLEN-1:0] apply_sign(input logic neg, input logic [XLEN-1:0] val);
    logic signed [XLEN-1:0] sval;
    sval = $signed(val);
    return neg ? $unsigned(-sval) : val;
  endfunction

  div_operand_prep #(.XLEN(XLEN)) u_prep (
    .op        (req_op),
    .rs1       (req_rs1),
    .rs2       (req_rs2),
    .dividend  (p_dividend),
    .divisor   (p_divisor),
    .div_zero  (p_zero),
    .is_rem    (p_is_rem),
    .outsign_q (p_outsign_q),
    .outsign_r (p_outsign_r)
  );

  assign req_ready = (state == IDLE) && !reset;
  assign accept    = req_valid && req_ready;
  assign rsp_valid = (state == DONE);
  assign busy      = (state == RUN) || (state == DONE);

  // One restoring step: subtract when the aligned divisor fits (63-bit unsigned compare).
  assign take         = (divisor <= {{(XLEN-1){1'b0}}, dividend});
  assign dividend_nxt = take ? (dividend - divisor[XLEN-1:0]) : dividend;
  assign quotient_nxt = take ? (quotient | mask) : quotient;

  // State register; reset aborts any request in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state selection.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = (ZERO_FAST && p_zero) ? DONE : RUN;
      RUN:  if (cnt == CNT_LAST) state_nxt = DONE;
      DONE: if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture, iteration registers and result capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dividend  <= '0;
      divisor   <= '0;
      quotient  <= '0;
      mask      <= '0;
      cnt       <= '0;
      is_rem    <= 1'b0;
      outsign_q <= 1'b0;
      outsign_r <= 1'b0;
      rsp_data  <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          dividend  <= p_dividend;
          divisor   <= p_divisor;
          quotient  <= '0;
          mask      <= {1'b1, {(XLEN-1){1'b0}}};
          cnt       <= '0;
          is_rem    <= p_is_rem;
          outsign_q <= p_outsign_q;
          outsign_r <= p_outsign_r;
          if (ZERO_FAST && p_zero)
            rsp_data <= p_is_rem ? req_rs1 : {XLEN{1'b1}};
        end
        RUN: begin
          dividend <= dividend_nxt;
          quotient <= quotient_nxt;
          divisor  <= divisor >> 1;
          mask     <= mask >> 1;
          cnt      <= cnt + 1'b1;
          if (cnt == CNT_LAST)
            rsp_data <= is_rem ? apply_sign(outsign_r, dividend_nxt)
                               : apply_sign(outsign_q, quotient_nxt);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_sequencer.sv
// Self-checking bench for div_sequencer: a cycle-level behavioural model
// derived from RISC-V division semantics, directed vectors with literal
// expectations, randomized traffic and an asynchronous mid-run reset.
module tb_div_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;

  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_op = 2'b00;
  logic [31:0] req_rs1 = '0;
  logic [31:0] req_rs2 = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic        busy;

  logic        s_req_valid = 1'b0;
  logic        s_req_ready;
  logic [1:0]  s_req_op = 2'b00;
  logic [31:0] s_req_rs1 = '0;
  logic [31:0] s_req_rs2 = '0;
  logic        s_rsp_valid;
  logic        s_rsp_ready = 1'b0;
  logic [31:0] s_rsp_data;
  logic        s_busy;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  div_sequencer #(.XLEN(32), .ZERO_FAST(1'b1)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_rs1(req_rs1), .req_rs2(req_rs2),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .busy(busy)
  );

  div_sequencer #(.XLEN(32), .ZERO_FAST(1'b0)) dut_slow (
    .clk(clk), .reset(reset),
    .req_valid(s_req_valid), .req_ready(s_req_ready), .req_op(s_req_op),
    .req_rs1(s_req_rs1), .req_rs2(s_req_rs2),
    .rsp_valid(s_rsp_valid), .rsp_ready(s_rsp_ready), .rsp_data(s_rsp_data),
    .busy(s_busy)
  );

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // RISC-V M-extension result, computed with wide integer arithmetic.
  function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
    if (!op[0]) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return op[1] ? 32'(sa % sb) : 32'(sa / sb);
    end
    return op[1] ? (a % b) : (a / b);
  endfunction

  // Behavioural model of the fast instance: 0 idle, 1 computing, 2 holding result.
  int          m_st   = 0;
  int          m_left = 0;
  logic [31:0] m_data = '0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_st   <= 0;
      m_left <= 0;
      m_data <= '0;
    end else begin
      case (m_st)
        0: if (req_valid) begin
          m_data <= ref_result(req_op, req_rs1, req_rs2);
          if (req_rs2 == 32'd0) m_st <= 2;
          else begin
            m_st   <= 1;
            m_left <= 32;
          end
        end
        1: begin
          m_left <= m_left - 1;
          if (m_left == 1) m_st <= 2;
        end
        default: if (rsp_ready) m_st <= 0;
      endcase
    end
  end

  // Per-cycle comparison of the fast instance against the model.
  always @(negedge clk) begin
    check1("req_ready", req_ready, (m_st == 0) && !reset);
    check1("busy", busy, m_st != 0);
    check1("rsp_valid", rsp_valid, m_st == 2);
    if (m_st != 1) check32("rsp_data", rsp_data, m_data);
  end

  // Present a request and return at the first falling edge after acceptance.
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    int n;
    req_op = op; req_rs1 = a; req_rs2 = b; req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 200) begin @(negedge clk); n++; end
    if (!req_ready) begin
      checks++; fails++;
      $display("FAIL accept_timeout: got no req_ready expected req_ready within 200 cycles");
    end
    @(negedge clk);
    req_valid = 1'b0;
    req_op = 2'($urandom); req_rs1 = $urandom; req_rs2 = $urandom;
  endtask

  // Count edges (accept edge included) until rsp_valid is seen.
  task automatic wait_rsp(output int lat);
    lat = 1;
    while (!rsp_valid && lat < 200) begin @(negedge clk); lat++; end
    if (!rsp_valid) begin
      checks++; fails++;
      $display("FAIL rsp_timeout: got no rsp_valid expected rsp_valid within 200 cycles");
    end
  endtask

  task automatic release_rsp(input int hold);
    repeat (hold) @(negedge clk);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic do_txn(input string name, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int exp_lat, input logic [31:0] exp_data);
    int lat;
    issue(op, a, b);
    wait_rsp(lat);
    check32({name, "_latency"}, 32'(lat), 32'(exp_lat));
    check32({name, "_data"}, rsp_data, exp_data);
    release_rsp(0);
  endtask

  task automatic slow_txn(input string name, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int exp_lat, input logic [31:0] exp_data);
    int n, lat;
    s_req_op = op; s_req_rs1 = a; s_req_rs2 = b; s_req_valid = 1'b1;
    n = 0;
    while (!s_req_ready && n < 200) begin @(negedge clk); n++; end
    @(negedge clk);
    s_req_valid = 1'b0;
    lat = 1;
    while (!s_rsp_valid && lat < 200) begin @(negedge clk); lat++; end
    check32({name, "_latency"}, 32'(lat), 32'(exp_lat));
    check32({name, "_data"}, s_rsp_data, exp_data);
    s_rsp_ready = 1'b1;
    @(negedge clk);
    s_rsp_ready = 1'b0;
    check1({name, "_idle"}, s_busy, 1'b0);
  endtask

  logic [1:0]  t_op  [10] = '{2'd1, 2'd3, 2'd0, 2'd2, 2'd0, 2'd2, 2'd0, 2'd2, 2'd1, 2'd2};
  logic [31:0] t_a   [10] = '{32'd100, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd7, 32'd7,
                              32'h8000_0000, 32'h8000_0000, 32'd5, 32'hFFFF_FFFB};
  logic [31:0] t_b   [10] = '{32'd7, 32'd7, 32'd2, 32'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFE,
                              32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0};
  logic [31:0] t_exp [10] = '{32'd14, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'd1,
                              32'h8000_0000, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFB};
  int          t_lat [10] = '{33, 33, 33, 33, 33, 33, 33, 33, 1, 1};

  initial begin
    int lat;
    int stray;
    logic [31:0] held;
    logic [31:0] a, b;
    logic [1:0]  op;

    #1 reset = 1'b1;
    repeat (3) @(negedge clk);
    check1("reset_rsp_valid", rsp_valid, 1'b0);
    check1("reset_busy", busy, 1'b0);
    check32("reset_rsp_data", rsp_data, 32'd0);
    check1("reset_req_ready", req_ready, 1'b0);
    reset = 1'b0;
    @(negedge clk);

    // Pin the reference model with hand-computed values.
    check32("model_divu_100_7", ref_result(2'd1, 32'd100, 32'd7), 32'd14);
    check32("model_rem_m7_2", ref_result(2'd2, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFF);
    check32("model_div_ovf", ref_result(2'd0, 32'h8000_0000, 32'hFFFF_FFFF), 32'h8000_0000);
    check32("model_rem_by0", ref_result(2'd2, 32'hFFFF_FFFB, 32'd0), 32'hFFFF_FFFB);

    for (int i = 0; i < 10; i++)
      do_txn($sformatf("vec%0d", i), t_op[i], t_a[i], t_b[i], t_lat[i], t_exp[i]);

    // Back-pressure: result held, new request ignored until the handshake.
    issue(2'd3, 32'd100, 32'd7);
    wait_rsp(lat);
    held = rsp_data;
    check32("hold_first", held, 32'd2);
    req_op = 2'd1; req_rs1 = 32'd1000; req_rs2 = 32'd10; req_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check32("hold_data", rsp_data, held);
      check1("hold_req_ready", req_ready, 1'b0);
      check1("hold_busy", busy, 1'b1);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check1("post_release_ready", req_ready, 1'b1);
    @(negedge clk);
    req_valid = 1'b0;
    check1("next_accepted_busy", busy, 1'b1);
    wait_rsp(lat);
    check32("next_latency", 32'(lat), 32'd33);
    check32("next_data", rsp_data, 32'd100);
    release_rsp(0);

    // Asynchronous reset in the middle of iteration 15.
    issue(2'd1, 32'h1234_5678, 32'd3);
    repeat (14) @(negedge clk);
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    check1("abort_rsp_valid", rsp_valid, 1'b0);
    check1("abort_busy", busy, 1'b0);
    check32("abort_rsp_data", rsp_data, 32'd0);
    reset = 1'b0;
    stray = 0;
    repeat (40) begin
      @(negedge clk);
      if (rsp_valid) stray++;
    end
    check32("abort_no_stale", 32'(stray), 32'd0);
    do_txn("after_abort", 2'd1, 32'd1000, 32'd10, 33, 32'd100);

    // Randomized traffic checked by the per-cycle model.
    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom);
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = $urandom_range(1, 15);
        3: b = -$urandom_range(1, 15);
        4: a = $urandom_range(0, 100);
        default: ;
      endcase
      issue(op, a, b);
      wait_rsp(lat);
      release_rsp($urandom_range(0, 3));
    end

    // Zero divisor without the fast path takes the full iteration count.
    slow_txn("slow_divu_by0", 2'd1, 32'd5, 32'd0, 33, 32'hFFFF_FFFF);
    slow_txn("slow_rem_by0", 2'd2, 32'hFFFF_FFFB, 32'd0, 33, 32'hFFFF_FFFB);
    slow_txn("slow_div_ovf", 2'd0, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'h8000_0000);
    slow_txn("slow_rem_m7_2", 2'd2, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFF);

    @(negedge clk);
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
